// File: rtl/framebuffer_stream_engine.sv
// Framebuffer stream engine: streams framebuffer words out over AXI-Stream (commit),
// fills them with a clear colour under a scissor mask (memset), or loads them from a stream (load).
module framebuffer_stream_engine #(
   parameter int PIXELS_PER_BEAT = 2,
   parameter int SUB_PIXELS      = 4,
   parameter int SUB_PIXEL_WIDTH = 8,
   parameter int X_BIT_WIDTH     = 11,
   parameter int Y_BIT_WIDTH     = 11,
   parameter int ADDR_WIDTH      = 18,
   parameter int READ_LATENCY    = 1,
   localparam int PW  = SUB_PIXELS * SUB_PIXEL_WIDTH,
   localparam int PPB = PIXELS_PER_BEAT,
   localparam int MAW = ADDR_WIDTH - $clog2(PIXELS_PER_BEAT)
) (
   input  logic                      aclk,
   input  logic                      resetn,
   input  logic [PW-1:0]             confClearColor,
   input  logic [SUB_PIXELS-1:0]     confMask,
   input  logic                      confEnableScissor,
   input  logic [X_BIT_WIDTH-1:0]    confScissorStartX,
   input  logic [X_BIT_WIDTH-1:0]    confScissorEndX,
   input  logic [Y_BIT_WIDTH-1:0]    confScissorStartY,
   input  logic [Y_BIT_WIDTH-1:0]    confScissorEndY,
   input  logic [X_BIT_WIDTH-1:0]    confXResolution,
   input  logic [Y_BIT_WIDTH-1:0]    confYResolution,
   input  logic [Y_BIT_WIDTH-1:0]    confYOffset,
   input  logic                      apply,
   output logic                      applied,
   input  logic                      cmdCommit,
   input  logic                      cmdMemset,
   input  logic                      cmdLoad,
   input  logic [ADDR_WIDTH:0]       cmdSize,
   output logic [PPB*PW-1:0]         writeData,
   output logic                      writeEnable,
   output logic [MAW-1:0]            writeAddr,
   output logic [PPB*SUB_PIXELS-1:0] writeMask,
   output logic [MAW-1:0]            readAddr,
   input  logic [PPB*PW-1:0]         readData,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [PPB*PW-1:0]         m_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   input  logic [PPB*PW-1:0]         s_axis_tdata
);

   // state  | meaning
   // IDLE   | waiting for apply; applied follows ~apply
   // COMMIT | reading words 0..N-1 and streaming them out on m_axis
   // MEMSET | writing the clear colour to words 0..N-1 under the scissor mask
   // LOAD   | writing s_axis beats to words 0..N-1 until N beats or tlast
   localparam int LOG2_PPB = $clog2(PIXELS_PER_BEAT);
   localparam int NW       = MAW + 1;
   localparam int DEPTH    = READ_LATENCY + 1;
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_W    = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_MEMSET, S_LOAD} state_t;

   state_t                   state_q, state_d;
   logic                     applied_q, applied_d;
   logic                     pend_q, pend_d;
   logic [NW-1:0]            n_q, n_d, idx_q, idx_d, beat_q, beat_d;
   logic [X_BIT_WIDTH-1:0]   x_q, x_d;
   logic [Y_BIT_WIDTH-1:0]   y_q, y_d;
   logic                     sc_en_q;
   logic [X_BIT_WIDTH-1:0]   sx0_q, sx1_q;
   logic [Y_BIT_WIDTH-1:0]   sy0_q, sy1_q;

   logic [PPB*PW-1:0]        fifo_mem [DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [READ_LATENCY-1:0]  pipe_q;
   logic                     issue, push, pop, latch;
   logic [PPB*SUB_PIXELS-1:0] ms_mask;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic in_scissor(input logic [X_BIT_WIDTH-1:0] px);
      return !sc_en_q || (px >= sx0_q && px < sx1_q && y_q >= sy0_q && y_q < sy1_q);
   endfunction

   assign applied       = applied_q;
   assign latch         = (state_q == S_IDLE) && apply;
   assign push          = pipe_q[READ_LATENCY-1];
   assign m_axis_tvalid = (cnt_q != '0);
   assign m_axis_tdata  = fifo_mem[rd_ptr_q];
   assign m_axis_tlast  = m_axis_tvalid && (beat_q == n_q - 1'b1);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign readAddr      = idx_q[MAW-1:0];
   // A beat leaving the FIFO this cycle frees its slot for a new read.
   assign issue = (state_q == S_COMMIT) && (idx_q < n_q) &&
                  ((int'(cnt_q) + $countones(pipe_q) - int'(pop)) < DEPTH);

   always_comb begin
      ms_mask = '0;
      for (int i = 0; i < PPB; i++)
         ms_mask[i*SUB_PIXELS +: SUB_PIXELS] =
            confMask & {SUB_PIXELS{in_scissor(x_q + X_BIT_WIDTH'(i))}};
   end

   always_comb begin
      state_d       = state_q;
      applied_d     = 1'b0;
      pend_d        = pend_q;
      n_d           = n_q;
      idx_d         = idx_q;
      beat_d        = beat_q;
      x_d           = x_q;
      y_d           = y_q;
      writeEnable   = 1'b0;
      writeAddr     = idx_q[MAW-1:0];
      writeData     = '0;
      writeMask     = '0;
      s_axis_tready = 1'b0;
      case (state_q)
         S_IDLE: begin
            applied_d = ~apply;
            if (apply) begin
               n_d    = NW'(cmdSize >> LOG2_PPB);
               idx_d  = '0;
               beat_d = '0;
               x_d    = '0;
               y_d    = confYOffset + confYResolution - 1'b1;
               pend_d = 1'b0;
               if (cmdCommit) begin
                  state_d = S_COMMIT;
                  pend_d  = cmdMemset;
               end else if (cmdLoad)   state_d = S_LOAD;
               else if (cmdMemset)     state_d = S_MEMSET;
            end
         end
         S_COMMIT: begin
            if (issue) idx_d = idx_q + 1'b1;
            if (pop) beat_d = beat_q + 1'b1;
            if ((pop && m_axis_tlast) || n_q == '0) begin
               state_d = pend_q ? S_MEMSET : S_IDLE;
               pend_d  = 1'b0;
               idx_d   = '0;
            end
         end
         S_MEMSET: begin
            if (idx_q < n_q) begin
               writeEnable = 1'b1;
               writeData   = {PPB{confClearColor}};
               writeMask   = ms_mask;
               idx_d       = idx_q + 1'b1;
               if ((x_q + X_BIT_WIDTH'(PPB)) == confXResolution) begin
                  x_d = '0;
                  y_d = y_q - 1'b1;
               end else begin
                  x_d = x_q + X_BIT_WIDTH'(PPB);
               end
               if (idx_q == n_q - 1'b1) state_d = S_IDLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (idx_q < n_q) begin
               s_axis_tready = 1'b1;
               if (s_axis_tvalid) begin
                  writeEnable = 1'b1;
                  writeData   = s_axis_tdata;
                  writeMask   = {PPB{confMask}};
                  idx_d       = idx_q + 1'b1;
                  if (idx_q == n_q - 1'b1 || s_axis_tlast) state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         applied_q <= 1'b1;
         pend_q    <= 1'b0;
         n_q       <= '0;
         idx_q     <= '0;
         beat_q    <= '0;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         state_q   <= state_d;
         applied_q <= applied_d;
         pend_q    <= pend_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         beat_q    <= beat_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         sc_en_q <= 1'b0;
         sx0_q   <= '0;
         sx1_q   <= '0;
         sy0_q   <= '0;
         sy1_q   <= '0;
      end else if (latch) begin
         sc_en_q <= confEnableScissor;
         sx0_q   <= confScissorStartX;
         sx1_q   <= confScissorEndX;
         sy0_q   <= confScissorStartY;
         sy1_q   <= confScissorEndY;
      end
   end

   // Read-return pipeline and output FIFO; reset drops anything still in flight.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         pipe_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         pipe_q <= READ_LATENCY'({pipe_q, issue});
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge aclk) begin
      if (push) fifo_mem[wr_ptr_q] <= readData;
   end

endmodule

// File: doc/framebuffer_stream_engine.md
FRAMEBUFFER_STREAM_ENGINE -- requirements
Module: framebuffer_stream_engine

Interface
REQ-001 SHALL have parameter PIXELS_PER_BEAT, default 2: pixels per stream beat and per memory word; power of two.
REQ-002 SHALL have parameters SUB_PIXELS=4 and SUB_PIXEL_WIDTH=8; PW = SUB_PIXELS*SUB_PIXEL_WIDTH.
REQ-003 SHALL have parameters X_BIT_WIDTH=11, Y_BIT_WIDTH=11 and ADDR_WIDTH=18 (pixel address width); MAW = ADDR_WIDTH-log2(PIXELS_PER_BEAT).
REQ-004 SHALL have parameter READ_LATENCY, default 1, range 1..4: memory read latency in cycles.
REQ-005 SHALL have ports aclk in 1 (clock) and resetn in 1 (reset); reset resetn, synchronous, active-low; clock aclk.
REQ-006 SHALL have confClearColor in PW, confMask in SUB_PIXELS and confEnableScissor in 1.
REQ-007 SHALL have confScissorStartX/EndX in X_BIT_WIDTH and confScissorStartY/EndY in Y_BIT_WIDTH.
REQ-008 SHALL have confXResolution in X_BIT_WIDTH, and confYResolution and confYOffset in Y_BIT_WIDTH.
REQ-009 SHALL have apply in 1, applied out 1, cmdCommit/cmdMemset/cmdLoad in 1 each, and cmdSize in ADDR_WIDTH+1 (pixels).
REQ-010 SHALL have writeData out PPB*PW, writeEnable out 1, writeAddr out MAW and writeMask out PPB*SUB_PIXELS.
REQ-011 SHALL have readAddr out MAW and readData in PPB*PW, valid READ_LATENCY cycles after the address.
REQ-012 SHALL have m_axis_tvalid out, m_axis_tready in, m_axis_tlast out and m_axis_tdata out PPB*PW.
REQ-013 SHALL have s_axis_tvalid in, s_axis_tready out, s_axis_tlast in and s_axis_tdata in PPB*PW.

Function
REQ-014 States: IDLE, COMMIT, MEMSET, LOAD.
REQ-015 In IDLE, applied SHALL be 1 the cycle after apply=0 is seen; apply=1 SHALL clear applied at the next edge and latch N = cmdSize>>log2(PPB) beats plus the scissor config.
REQ-016 Apply priority: cmdCommit goes to COMMIT (memsetPending=cmdMemset); otherwise cmdLoad goes to LOAD; otherwise cmdMemset goes to MEMSET; with no command bit set, stay in IDLE.
REQ-017 apply SHALL be ignored outside IDLE; N=0 SHALL complete a command with no memory or stream traffic.
REQ-018 COMMIT: issue reads at addresses 0..N-1, one per cycle, only while (output FIFO occupancy + reads in flight) < READ_LATENCY+1; returned data enters a FIFO of that depth.
REQ-019 m_axis SHALL be driven from the FIFO head; tdata/tlast SHALL stay stable while tvalid=1 and tready=0; tlast=1 on beat N-1 only.
REQ-020 COMMIT SHALL sustain 1 beat/cycle with tready held high, and SHALL never drop, duplicate or reorder beats.
REQ-021 After the tlast handshake: go to MEMSET if memsetPending, else to IDLE.
REQ-022 MEMSET: one beat per cycle, index 0..N-1, writeEnable=1, writeData = confClearColor replicated PPB times.
REQ-023 MEMSET mask = confMask replicated, ANDed per pixel with the scissor test startX<=x<endX and startY<=y<endY; scissor disabled means the test passes.
REQ-024 MEMSET coordinates: x starts at 0 and y at confYOffset+confYResolution-1; on x+PPB==confXResolution, x wraps to 0 and y decrements by 1; pixel i of a beat has x+i.
REQ-025 writeEnable SHALL drop in the cycle after the last write beat; state returns to IDLE.
REQ-026 LOAD: s_axis_tready=1; each handshake writes tdata at the current index with mask = confMask replicated (no scissor).
REQ-027 LOAD SHALL end after N beats or on an s_axis_tlast beat, whichever comes first; s_axis_tready=0 in every other state.
REQ-028 Index and coordinate arithmetic SHALL wrap modulo the field width with no overflow flag.

Reset
REQ-029 On resetn=0 (including mid-command): state IDLE, applied=1, writeEnable=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0, FIFO empty, memsetPending=0; in-flight reads are discarded.

Verification (PPB=2, READ_LATENCY=2, 8x4 resolution, confYOffset=0)
REQ-030 Commit, cmdSize=32, tready=1 -> 16 beats of mem[0..15] on consecutive cycles, tlast on beat 16, applied=1 afterwards.
REQ-031 Commit, cmdSize=32, tready toggling 1/0 each cycle -> same 16 beats in order, tdata stable while stalled.
REQ-032 Memset, color 0xAABBCCDD, mask 4'b1111, scissor x[2,6) y[1,3) -> 16 write beats, mask set only for pixels inside the scissor region, others 0.
REQ-033 Commit+memset in one apply -> all 16 stream beats precede the first writeEnable; applied=1 after the final write.
REQ-034 Load, cmdSize=32, s_axis_tlast on beat 10 -> 10 writes to addresses 0..9, then IDLE, s_axis_tready=0.
REQ-035 resetn=0 after the 5th commit beat -> tvalid=0 and applied=1 at the next edge; a new commit then restarts at address 0.
